// File: rtl/mystic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mystic_pkg
// Description : Shared definitions for the instruction realigner: RV64I major
//               opcodes, RVC quadrant / funct3 codes, the halfword type and
//               the compressed-register to full-register mapping.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mystic_pkg;

  localparam int unsigned HW_W = 16;
  typedef logic [HW_W-1:0] halfword_t;

  // RV64I major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // RVC quadrants (instr[1:0]); Q3 means a 32-bit instruction
  localparam logic [1:0] RVC_Q0 = 2'b00;
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;
  localparam logic [1:0] RVC_Q3 = 2'b11;

  // Quadrant 0 funct3
  localparam logic [2:0] C0_ADDI4SPN = 3'b000;
  localparam logic [2:0] C0_FLD      = 3'b001;
  localparam logic [2:0] C0_LW       = 3'b010;
  localparam logic [2:0] C0_LD       = 3'b011;
  localparam logic [2:0] C0_RSV      = 3'b100;
  localparam logic [2:0] C0_FSD      = 3'b101;
  localparam logic [2:0] C0_SW       = 3'b110;
  localparam logic [2:0] C0_SD       = 3'b111;

  // Quadrant 1 funct3
  localparam logic [2:0] C1_ADDI  = 3'b000;
  localparam logic [2:0] C1_ADDIW = 3'b001;
  localparam logic [2:0] C1_LI    = 3'b010;
  localparam logic [2:0] C1_LUI   = 3'b011;
  localparam logic [2:0] C1_MISC  = 3'b100;
  localparam logic [2:0] C1_J     = 3'b101;
  localparam logic [2:0] C1_BEQZ  = 3'b110;
  localparam logic [2:0] C1_BNEZ  = 3'b111;

  // Quadrant 2 funct3
  localparam logic [2:0] C2_SLLI  = 3'b000;
  localparam logic [2:0] C2_FLDSP = 3'b001;
  localparam logic [2:0] C2_LWSP  = 3'b010;
  localparam logic [2:0] C2_LDSP  = 3'b011;
  localparam logic [2:0] C2_JMV   = 3'b100;
  localparam logic [2:0] C2_FSDSP = 3'b101;
  localparam logic [2:0] C2_SWSP  = 3'b110;
  localparam logic [2:0] C2_SDSP  = 3'b111;

  // 3-bit compressed register field selects x8..x15
  function automatic logic [4:0] creg2xreg(input logic [2:0] creg);
    return {2'b01, creg};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mystic_rvc_expander.sv
`default_nettype none
// ============================================================================
// Module      : mystic_rvc_expander
// Description : Combinational RV64C -> RV64I expander.
// Ports       : instr_i   [15:0] compressed instruction (quadrants 0-2)
//               instr_o   [31:0] expanded instruction; {16'h0, instr_i} when
//                                illegal or for quadrant 3
//               illegal_o        reserved / unsupported (FP) encoding
// Revision    : 1.0 - initial release
// ============================================================================
module mystic_rvc_expander
  import mystic_pkg::*;
(
  input  logic [15:0] instr_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [5:0]  imm6;
  logic [11:0] imm6_sx;
  logic [11:0] a4spn_imm, lw_imm, ld_imm, a16sp_imm;
  logic [11:0] lwsp_imm, ldsp_imm, swsp_imm, sdsp_imm;
  logic [19:0] lui_imm;
  logic [11:1] j_off;
  logic [12:1] b_off;

  assign rd   = instr_i[11:7];
  assign rs2  = instr_i[6:2];
  assign rdp  = creg2xreg(instr_i[4:2]);
  assign rs1p = creg2xreg(instr_i[9:7]);
  assign imm6 = {instr_i[12], instr_i[6:2]};
  assign imm6_sx = {{6{instr_i[12]}}, imm6};

  // Immediate scrambles of the individual RVC formats, zero/sign extended
  assign a4spn_imm = {2'b00, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00};
  assign lw_imm    = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
  assign ld_imm    = {4'b0, instr_i[6:5], instr_i[12:10], 3'b000};
  assign a16sp_imm = {{3{instr_i[12]}}, instr_i[4:3], instr_i[5], instr_i[2], instr_i[6], 4'b0000};
  assign lui_imm   = {{14{instr_i[12]}}, instr_i[12], instr_i[6:2]};
  assign lwsp_imm  = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00};
  assign ldsp_imm  = {3'b0, instr_i[4:2], instr_i[12], instr_i[6:5], 3'b000};
  assign swsp_imm  = {4'b0, instr_i[8:7], instr_i[12:9], 2'b00};
  assign sdsp_imm  = {3'b0, instr_i[9:7], instr_i[12:10], 3'b000};
  assign j_off     = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                      instr_i[2], instr_i[11], instr_i[5:3]};
  assign b_off     = {{4{instr_i[12]}}, instr_i[12], instr_i[6:5], instr_i[2],
                      instr_i[11:10], instr_i[4:3]};

  always_comb begin
    instr_o   = {16'h0000, instr_i};
    illegal_o = 1'b0;
    case (instr_i[1:0])
      RVC_Q0: begin
        case (instr_i[15:13])
          C0_ADDI4SPN: begin
            // imm==0 also catches the all-zero halfword
            if (a4spn_imm == 12'd0) illegal_o = 1'b1;
            else instr_o = {a4spn_imm, 5'd2, 3'b000, rdp, OP_IMM};
          end
          C0_LW:  instr_o = {lw_imm, rs1p, 3'b010, rdp, OP_LOAD};
          C0_LD:  instr_o = {ld_imm, rs1p, 3'b011, rdp, OP_LOAD};
          C0_SW:  instr_o = {lw_imm[11:5], rdp, rs1p, 3'b010, lw_imm[4:0], OP_STORE};
          C0_SD:  instr_o = {ld_imm[11:5], rdp, rs1p, 3'b011, ld_imm[4:0], OP_STORE};
          C0_FLD, C0_RSV, C0_FSD: illegal_o = 1'b1;
          default: illegal_o = 1'b1;
        endcase
      end
      RVC_Q1: begin
        case (instr_i[15:13])
          C1_ADDI:  instr_o = {imm6_sx, rd, 3'b000, rd, OP_IMM};
          C1_ADDIW: instr_o = {imm6_sx, rd, 3'b000, rd, OP_IMM32};
          C1_LI:    instr_o = {imm6_sx, 5'd0, 3'b000, rd, OP_IMM};
          C1_LUI: begin
            if (imm6 == 6'd0) illegal_o = 1'b1;
            else if (rd == 5'd2) instr_o = {a16sp_imm, 5'd2, 3'b000, 5'd2, OP_IMM};
            else instr_o = {lui_imm, rd, OP_LUI};
          end
          C1_MISC: begin
            case (instr_i[11:10])
              2'b00: instr_o = {6'b000000, imm6, rs1p, 3'b101, rs1p, OP_IMM};
              2'b01: instr_o = {6'b010000, imm6, rs1p, 3'b101, rs1p, OP_IMM};
              2'b10: instr_o = {imm6_sx, rs1p, 3'b111, rs1p, OP_IMM};
              default: begin
                case ({instr_i[12], instr_i[6:5]})
                  3'b000: instr_o = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_OP};
                  3'b001: instr_o = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_OP};
                  3'b010: instr_o = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_OP};
                  3'b011: instr_o = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_OP};
                  3'b100: instr_o = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_OP32};
                  3'b101: instr_o = {7'b0000000, rdp, rs1p, 3'b000, rs1p, OP_OP32};
                  default: illegal_o = 1'b1;
                endcase
              end
            endcase
          end
          C1_J: instr_o = {j_off[11], j_off[10:1], j_off[11], {8{j_off[11]}}, 5'd0, OP_JAL};
          C1_BEQZ: instr_o = {b_off[12], b_off[10:5], 5'd0, rs1p, 3'b000,
                              b_off[4:1], b_off[11], OP_BRANCH};
          C1_BNEZ: instr_o = {b_off[12], b_off[10:5], 5'd0, rs1p, 3'b001,
                              b_off[4:1], b_off[11], OP_BRANCH};
          default: illegal_o = 1'b1;
        endcase
      end
      RVC_Q2: begin
        case (instr_i[15:13])
          C2_SLLI: instr_o = {6'b000000, imm6, rd, 3'b001, rd, OP_IMM};
          C2_LWSP: begin
            if (rd == 5'd0) illegal_o = 1'b1;
            else instr_o = {lwsp_imm, 5'd2, 3'b010, rd, OP_LOAD};
          end
          C2_LDSP: begin
            if (rd == 5'd0) illegal_o = 1'b1;
            else instr_o = {ldsp_imm, 5'd2, 3'b011, rd, OP_LOAD};
          end
          C2_JMV: begin
            if (!instr_i[12]) begin
              if (rs2 != 5'd0) instr_o = {7'd0, rs2, 5'd0, 3'b000, rd, OP_OP};      // c.mv
              else if (rd == 5'd0) illegal_o = 1'b1;                              // c.jr x0
              else instr_o = {12'd0, rd, 3'b000, 5'd0, OP_JALR};                  // c.jr
            end else begin
              if (rs2 != 5'd0) instr_o = {7'd0, rs2, rd, 3'b000, rd, OP_OP};        // c.add
              else if (rd == 5'd0) instr_o = {12'd1, 5'd0, 3'b000, 5'd0, OP_SYSTEM}; // c.ebreak
              else instr_o = {12'd0, rd, 3'b000, 5'd1, OP_JALR};                  // c.jalr
            end
          end
          C2_SWSP: instr_o = {swsp_imm[11:5], rs2, 5'd2, 3'b010, swsp_imm[4:0], OP_STORE};
          C2_SDSP: instr_o = {sdsp_imm[11:5], rs2, 5'd2, 3'b011, sdsp_imm[4:0], OP_STORE};
          C2_FLDSP, C2_FSDSP: illegal_o = 1'b1;
          default: illegal_o = 1'b1;
        endcase
      end
      RVC_Q3: begin
        // 32-bit instruction: not expanded here, the top bypasses this output
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mystic_instr_realigner.sv
`default_nettype none
// ============================================================================
// Module      : mystic_instr_realigner
// Description : Halfword queue between fetch and decode. Accepts fetch words,
//               realigns mixed 16/32-bit instructions (including ones that
//               straddle fetch words), expands RVC and delivers one
//               instruction per cycle with its PC. Supports flush/redirect.
// Ports       : clk_i, rst_i (async, active-high)
//               flush_i / flush_pc_i         redirect
//               fetch_valid_i / fetch_ready_o / fetch_data_i  fetch side
//               instr_valid_o / instr_ready_i / instr_o / instr_pc_o /
//               instr_compressed_o / instr_illegal_o          decode side
// Revision    : 1.0 - initial release
// ============================================================================
module mystic_instr_realigner
  import mystic_pkg::*;
#(
  parameter int unsigned     FETCH_W = 64,
  parameter int unsigned     BUF_HW  = 8,
  parameter int unsigned     XLEN    = 64,
  parameter logic [XLEN-1:0] BOOT_PC = 64'h8000_0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [XLEN-1:0]    flush_pc_i,
  input  logic               fetch_valid_i,
  output logic               fetch_ready_o,
  input  logic [FETCH_W-1:0] fetch_data_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [31:0]        instr_o,
  output logic [XLEN-1:0]    instr_pc_o,
  output logic               instr_compressed_o,
  output logic               instr_illegal_o
);

  localparam int unsigned NHW    = FETCH_W / HW_W;
  localparam int unsigned PTR_W  = $clog2(BUF_HW);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DROP_W = $clog2(NHW);

  halfword_t         buf_q [BUF_HW];
  halfword_t         buf_d [BUF_HW];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  halfword_t          h0, h1;
  logic               head_is_c, push, pop;
  logic [CNT_W-1:0]   push_cnt, pop_cnt;
  logic [FETCH_W-1:0] fetch_aligned;
  logic [31:0]        exp_instr;
  logic               exp_illegal;

  assign h0        = buf_q[head_q];
  assign h1        = buf_q[head_q + PTR_W'(1)];
  assign head_is_c = (h0[1:0] != 2'b11);

  // Derived from registered count only, so no ready->ready combinational path
  assign fetch_ready_o = (CNT_W'(BUF_HW) - count_q) >= CNT_W'(NHW);
  assign instr_valid_o = head_is_c ? (count_q != '0) : (count_q >= CNT_W'(2));

  assign push     = fetch_valid_i & fetch_ready_o;
  assign pop      = instr_valid_o & instr_ready_i;
  assign push_cnt = push ? (CNT_W'(NHW) - CNT_W'(drop_q)) : '0;
  assign pop_cnt  = pop ? (head_is_c ? CNT_W'(1) : CNT_W'(2)) : '0;

  // Leading halfwords before a redirect target are shifted out, the rest
  // are appended in address order starting at the tail.
  assign fetch_aligned = fetch_data_i >> {drop_q, 4'b0000};

  always_comb begin
    buf_d   = buf_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = flush_pc_i;
      drop_d  = flush_pc_i[DROP_W:1];
    end else begin
      for (int j = 0; j < NHW; j++) begin
        if (CNT_W'(j) < push_cnt) begin
          buf_d[tail_q + PTR_W'(j)] = fetch_aligned[HW_W*j +: HW_W];
        end
      end
      if (push) drop_d = '0;
      tail_d  = tail_q + PTR_W'(push_cnt);
      head_d  = head_q + PTR_W'(pop_cnt);
      pc_d    = pc_q + XLEN'({pop_cnt, 1'b0});
      count_d = count_q + push_cnt - pop_cnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BUF_HW; i++) buf_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pc_q    <= BOOT_PC;
      drop_q  <= '0;
    end else begin
      buf_q   <= buf_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  mystic_rvc_expander u_expander (
    .instr_i   (h0),
    .instr_o   (exp_instr),
    .illegal_o (exp_illegal)
  );

  // Outputs are gated by valid so stale queue contents never leak out
  assign instr_o            = !instr_valid_o ? 32'h0 : (head_is_c ? exp_instr : {h1, h0});
  assign instr_compressed_o = instr_valid_o & head_is_c;
  assign instr_illegal_o    = instr_valid_o & head_is_c & exp_illegal;
  assign instr_pc_o         = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mystic_instr_realigner.sv
`default_nettype none
// ============================================================================
// Module      : tb_mystic_instr_realigner
// Description : Directed self-checking bench for mystic_instr_realigner
//               (FETCH_W=64, BUF_HW=8, XLEN=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mystic_instr_realigner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [63:0] flush_pc = '0;
  logic        fv = 1'b0;
  logic        fready;
  logic [63:0] fdata = '0;
  logic        ivalid;
  logic        iready = 1'b0;
  logic [31:0] instr;
  logic [63:0] ipc;
  logic        icomp;
  logic        iill;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] BOOT = 64'h8000_0000;
  localparam logic [63:0] W_A  = 64'h0085_0010_0093_0085;
  localparam logic [63:0] W_C  = 64'h4505_4505_4505_4505;

  mystic_instr_realigner dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .flush_pc_i         (flush_pc),
    .fetch_valid_i      (fv),
    .fetch_ready_o      (fready),
    .fetch_data_i       (fdata),
    .instr_valid_o      (ivalid),
    .instr_ready_i      (iready),
    .instr_o            (instr),
    .instr_pc_o         (ipc),
    .instr_compressed_o (icomp),
    .instr_illegal_o    (iill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_instr(input string tag, input logic [31:0] e_instr,
                             input logic e_comp, input logic [63:0] e_pc);
    check({tag, "_valid"}, 64'(ivalid), 64'd1);
    check({tag, "_instr"}, 64'(instr), 64'(e_instr));
    check({tag, "_comp"},  64'(icomp), 64'(e_comp));
    check({tag, "_pc"},    ipc, e_pc);
  endtask

  logic [31:0] drain_instr [6] = '{32'h0010_8093, 32'h0010_0093, 32'h0010_8093,
                                   32'h0010_8093, 32'h0010_0093, 32'h0010_8093};
  logic        drain_comp  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [63:0] drain_pc    [6] = '{64'h8000_0010, 64'h8000_0012, 64'h8000_0016,
                                   64'h8000_0018, 64'h8000_001A, 64'h8000_001E};

  initial begin
    // ---- reset state
    tick();
    check("rst_valid", 64'(ivalid), 64'd0);
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_comp",  64'(icomp), 64'd0);
    check("rst_ill",   64'(iill), 64'd0);
    check("rst_pc",    ipc, BOOT);
    check("rst_fready", 64'(fready), 64'd1);
    rst = 1'b0;

    // ---- single RVC word: c.lw, then three illegal zero halfwords
    fv = 1'b1; fdata = 64'h0000_0000_0000_5BA0; iready = 1'b0;
    #1 check("lat_nocomb", 64'(ivalid), 64'd0);
    tick(); fv = 1'b0;
    check_instr("clw", 32'h0707_A403, 1'b1, 64'h8000_0000);
    check("clw_ill", 64'(iill), 64'd0);
    iready = 1'b1;
    tick();
    check_instr("ill0", 32'h0, 1'b1, 64'h8000_0002);
    check("ill0_ill", 64'(iill), 64'd1);
    tick();
    check("ill1_pc", ipc, 64'h8000_0004);
    tick();
    check("ill2_pc", ipc, 64'h8000_0006);
    tick();
    check("empty_valid", 64'(ivalid), 64'd0);
    check("empty_pc", ipc, 64'h8000_0008);

    // ---- mixed 16/32-bit word
    fv = 1'b1; fdata = W_A;
    tick(); fv = 1'b0;
    check_instr("mix0", 32'h0010_8093, 1'b1, 64'h8000_0008);
    tick();
    check_instr("mix1", 32'h0010_0093, 1'b0, 64'h8000_000A);
    tick();
    check_instr("mix2", 32'h0010_8093, 1'b1, 64'h8000_000E);
    tick();
    check("mix_end_valid", 64'(ivalid), 64'd0);
    check("mix_end_pc", ipc, 64'h8000_0010);

    // ---- backpressure: fill all 8 halfwords, hold decode off
    iready = 1'b0; fv = 1'b1; fdata = W_A;
    tick();
    check("bp_fready_half", 64'(fready), 64'd1);
    tick();
    fdata = W_C;
    check("bp_fready_full", 64'(fready), 64'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_stall_instr", 64'(instr), 64'h0010_8093);
      check("bp_stall_fready", 64'(fready), 64'd0);
      check("bp_stall_pc", ipc, 64'h8000_0010);
    end
    fv = 1'b0; iready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_instr("bp_drain", drain_instr[i], drain_comp[i], drain_pc[i]);
      tick();
    end
    check("bp_drain_end_valid", 64'(ivalid), 64'd0);
    check("bp_drain_end_pc", ipc, 64'h8000_0020);

    // ---- straddle: 32-bit low half at word end
    fv = 1'b1; fdata = 64'h0513_0085_0085_0085;
    tick(); fv = 1'b0;
    check_instr("str_pre", 32'h0010_8093, 1'b1, 64'h8000_0020);
    tick(); tick(); tick();
    check("str_wait_valid", 64'(ivalid), 64'd0);
    check("str_wait_instr", 64'(instr), 64'd0);
    check("str_wait_pc", ipc, 64'h8000_0026);
    tick();
    check("str_wait2_valid", 64'(ivalid), 64'd0);
    iready = 1'b0; fv = 1'b1; fdata = 64'h0001_0001_0001_0000;
    tick(); fv = 1'b0;
    check_instr("str_join", 32'h0000_0513, 1'b0, 64'h8000_0026);
    check("str_fready", 64'(fready), 64'd0);
    iready = 1'b1;
    tick();
    check_instr("cnop", 32'h0000_0013, 1'b1, 64'h8000_002A);
    check("cnop_fready", 64'(fready), 64'd1);

    // ---- flush with simultaneous push and pop
    flush = 1'b1; flush_pc = 64'h8000_1006; fv = 1'b1; fdata = W_C;
    tick();
    flush = 1'b0; fv = 1'b0;
    check("fl_valid", 64'(ivalid), 64'd0);
    check("fl_instr", 64'(instr), 64'd0);
    check("fl_pc", ipc, 64'h8000_1006);
    check("fl_fready", 64'(fready), 64'd1);
    iready = 1'b0; fv = 1'b1; fdata = 64'h4505_0085_0085_0085;
    tick(); fv = 1'b0;
    check_instr("fl_first", 32'h0010_0513, 1'b1, 64'h8000_1006);
    iready = 1'b1;
    tick();
    check("fl_after_valid", 64'(ivalid), 64'd0);
    check("fl_after_pc", ipc, 64'h8000_1008);

    // ---- asynchronous reset mid-stream
    iready = 1'b0; fv = 1'b1; fdata = W_A;
    tick(); fv = 1'b0;
    check("pre_rst_valid", 64'(ivalid), 64'd1);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", 64'(ivalid), 64'd0);
    check("arst_instr", 64'(instr), 64'd0);
    check("arst_comp",  64'(icomp), 64'd0);
    check("arst_pc",    ipc, BOOT);
    check("arst_fready", 64'(fready), 64'd1);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid", 64'(ivalid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
